// File: rtl/pfb_stream_pkg.sv
// Shared types and constants for the PFB stream input path.
package pfb_stream_pkg;

    // Frame-alignment state: SYNC discards input until a frame boundary is seen.
    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Width and saturation value of the input stall counter.
    localparam int STALL_CNT_W = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/pfb_skid_fifo.sv
// Two-entry FIFO that absorbs the one-cycle lag of a registered ready.
module pfb_skid_fifo #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   count_next
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;

    // Occupancy after this cycle; the writer must never push into a full FIFO.
    assign count_next = count + 2'(push) - 2'(pop);
    assign dout       = mem[rd_ptr];
    assign valid      = (count != 2'd0);

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset so the visible head reads zero out of reset.
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_next;
        end
    end

endmodule

// File: rtl/pfb_axis_input_reader.sv
// Deinterleaves a multichannel AXI-Stream into channel-tagged samples,
// aligning to frame boundaries and reporting framing errors and stalls.
module pfb_axis_input_reader
    import pfb_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [DATA_W-1:0]      s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [DATA_W-1:0]      m_data,
    output logic [CH_W-1:0]        m_ch,
    output logic                   m_sof,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   block,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    input  logic                   stall_clr,
    output logic                   err_framing,
    input  logic                   err_clr,
    output logic [31:0]            frame_cnt
);

    localparam int FW = DATA_W + CH_W + 1;
    localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_CH - 1);

    state_t          state, state_next;
    logic [CH_W-1:0] ch, ch_next;
    logic            accept, push, pop;
    logic            err_set, frame_inc, stall;
    logic [1:0]      count_next;
    logic [FW-1:0]   fifo_dout;

    assign accept = s_axis_tvalid && s_axis_tready;
    assign pop    = m_valid && m_ready;
    assign stall  = s_axis_tvalid && !s_axis_tready;

    pfb_skid_fifo #(.W(FW)) u_fifo (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .push       (push),
        .din        ({(ch == '0), ch, s_axis_tdata}),
        .pop        (pop),
        .dout       (fifo_dout),
        .valid      (m_valid),
        .count_next (count_next)
    );

    assign {m_sof, m_ch, m_data} = fifo_dout;

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= ST_SYNC;
        else           state <= state_next;
    end

    // Frame tracking: channel tagging, boundary checks, FIFO write decision.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_next = state;
        ch_next    = ch;
        push       = 1'b0;
        err_set    = 1'b0;
        frame_inc  = 1'b0;
        if (accept) begin
            case (state)
                ST_SYNC: if (s_axis_tlast) state_next = ST_RUN;
                ST_RUN: begin
                    push = 1'b1;
                    if (ch == CH_MAX) begin
                        ch_next = '0;
                        if (s_axis_tlast) begin
                            frame_inc = 1'b1;
                        end else begin
                            err_set    = 1'b1;
                            state_next = ST_SYNC;
                        end
                    end else if (s_axis_tlast) begin
                        ch_next = '0;
                        err_set = 1'b1;
                    end else begin
                        ch_next = ch + CH_W'(1);
                    end
                end
                default: state_next = ST_SYNC;
            endcase
        end
    end

    // Registered ready, channel counter, status flags and counters.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s_axis_tready <= 1'b0;
            ch            <= '0;
            block         <= 1'b0;
            stall_cnt     <= '0;
            err_framing   <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            // SYNC never writes the FIFO, so it can always accept.
            s_axis_tready <= (state_next == ST_SYNC) || (count_next != 2'd2);
            ch            <= ch_next;
            block         <= stall;
            if (stall_clr)
                stall_cnt <= '0;
            else if (stall && stall_cnt != STALL_CNT_MAX)
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            if (err_set)      err_framing <= 1'b1;
            else if (err_clr) err_framing <= 1'b0;
            if (frame_inc) frame_cnt <= frame_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pfb_axis_input_reader.sv
// Directed bench for pfb_axis_input_reader with hand-computed expectations.
module tb_pfb_axis_input_reader;
    import pfb_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_axis_tready;
    logic [31:0] m_data;
    logic [2:0]  m_ch;
    logic        m_sof, m_valid, m_ready;
    logic        block, stall_clr, err_framing, err_clr;
    logic [15:0] stall_cnt;
    logic [31:0] frame_cnt;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  ch;
        logic        sof;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    pfb_axis_input_reader dut (
        .ap_clk        (clk),
        .ap_rst_n      (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_axis_tready),
        .m_data        (m_data),
        .m_ch          (m_ch),
        .m_sof         (m_sof),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .block         (block),
        .stall_cnt     (stall_cnt),
        .stall_clr     (stall_clr),
        .err_framing   (err_framing),
        .err_clr       (err_clr),
        .frame_cnt     (frame_cnt)
    );

    // Record every output beat that will be popped on the coming edge.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) got_q.push_back('{m_data, m_ch, m_sof});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Offer one beat (called at posedge+1); returns at posedge+1 after acceptance.
    task automatic send_beat(input logic [31:0] d, input logic last);
        int waited = 0;
        bit done = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        while (!done) begin
            @(negedge clk);
            if (s_axis_tready) done = 1'b1;
            @(posedge clk); #1;
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    check("send_timeout", s_axis_tready, 1);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic send_run(input logic [31:0] base, input int n, input bit last_on_end);
        for (int i = 0; i < n; i++)
            send_beat(base + 32'(i), last_on_end && (i == n - 1));
    endtask

    // Expected beats of one contiguous run starting at channel 0.
    task automatic add_run(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{base + 32'(i), 3'(i), (i == 0)});
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_d%0d", tag, i), got_q[i].d, exp_q[i].d);
            check($sformatf("%s_ch%0d", tag, i), got_q[i].ch, exp_q[i].ch);
            check($sformatf("%s_sof%0d", tag, i), got_q[i].sof, exp_q[i].sof);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_ch"}, m_ch, 0);
        check({tag, "_m_sof"}, m_sof, 0);
        check({tag, "_tready"}, s_axis_tready, 0);
        check({tag, "_block"}, block, 0);
        check({tag, "_stall_cnt"}, stall_cnt, 0);
        check({tag, "_err"}, err_framing, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        logic rdy;
        int   idx;
        rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_ready = 1'b0; stall_clr = 1'b0; err_clr = 1'b0;

        // Reset state, then ready rises on the first edge after release.
        #3;
        check_cleared("rst");
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1 check("rel_tready_before_edge", s_axis_tready, 0);
        @(posedge clk); #1;
        check("rel_tready_after_edge", s_axis_tready, 1);

        // First frame only synchronises; second is emitted tagged 0..7.
        m_ready = 1'b1;
        send_run(32'h00, 8, 1'b1);
        send_run(32'h10, 8, 1'b1);
        drain();
        add_run(32'h10, 8);
        compare_q("good_frame");
        check("good_frame_cnt", frame_cnt, 1);
        check("good_err", err_framing, 0);

        // Single beat into an empty FIFO is visible the next cycle.
        send_beat(32'h30, 1'b0);
        check("lat_valid", m_valid, 1);
        check("lat_data", m_data, 32'h30);
        check("lat_sof", m_sof, 1);

        // Early tlast on the 4th beat: error, next beat restarts at channel 0.
        send_run(32'h31, 3, 1'b1);
        idle();
        check("early_err", err_framing, 1);
        check("early_frame_cnt", frame_cnt, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_clr", err_framing, 0);
        send_run(32'h34, 8, 1'b1);
        drain();
        add_run(32'h30, 4);
        add_run(32'h34, 8);
        compare_q("early");
        check("early_frame_cnt2", frame_cnt, 2);

        // Missing tlast: error (wins over a same-cycle clear), resync discards.
        send_run(32'h40, 7, 1'b0);
        err_clr = 1'b1;
        send_beat(32'h47, 1'b0);
        err_clr = 1'b0;
        check("late_err_vs_clr", err_framing, 1);
        send_run(32'h50, 3, 1'b1);
        send_run(32'h60, 8, 1'b1);
        drain();
        add_run(32'h40, 8);
        add_run(32'h60, 8);
        compare_q("late");
        check("late_frame_cnt", frame_cnt, 3);

        // Output backpressure for 10 cycles with the input always offering.
        m_ready  = 1'b0;
        idx      = 0;
        s_tdata  = 32'h70;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            rdy = s_axis_tready;
            if (c <= 3) check($sformatf("bp_tready_c%0d", c), rdy, (c <= 2));
            if (c == 3 || c == 4) check($sformatf("bp_block_c%0d", c), block, (c == 4));
            @(posedge clk); #1;
            if (rdy) begin
                idx++;
                s_tdata = 32'h70 + 32'(idx);
            end
        end
        idle();
        check("bp_accepts", 64'(idx), 2);
        check("bp_hold_valid", m_valid, 1);
        check("bp_hold_data", m_data, 32'h70);
        check("bp_hold_ch", m_ch, 0);
        @(negedge clk);
        check("bp_stall_cnt", stall_cnt, 8);
        check("bp_block_last", block, 1);
        @(posedge clk); #1;
        check("bp_block_clear", block, 0);
        stall_clr = 1'b1;
        @(posedge clk); #1;
        stall_clr = 1'b0;
        check("bp_stall_clr", stall_cnt, 0);
        m_ready = 1'b1;
        send_run(32'h72, 6, 1'b1);
        drain();
        add_run(32'h70, 8);
        compare_q("bp");
        check("bp_frame_cnt", frame_cnt, 4);

        // Reset mid-frame with two beats buffered.
        m_ready = 1'b0;
        send_run(32'h80, 2, 1'b0);
        idle();
        check("mid_valid_before", m_valid, 1);
        #2 rst_n = 1'b0;
        #1 check_cleared("mid_rst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_tready", s_axis_tready, 1);
        m_ready = 1'b1;
        send_run(32'h90, 5, 1'b1);
        send_run(32'hA0, 8, 1'b1);
        drain();
        add_run(32'hA0, 8);
        compare_q("mid");
        check("mid_frame_cnt", frame_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
